toy_bpu_btb_arb: RTL and testbench

Controller that owns the single BTB SRAM port and shares it between two requesters: the prediction lookup path (read) and the decoder update path (write).
- Runs a zero-fill sweep of every BTB index after reset and on software flush.
- Buffers updates in a small FIFO.
- Arbitrates lookup against update with a starvation limit.
- Sits between the BTB lookup logic and the BTB entry memory.

---
 rtl/toy_pack.sv | 12 +
 rtl/toy_bpu_btb_arb_if.sv | 33 +++
 rtl/toy_bpu_btb_upd_fifo.sv | 45 ++++
 rtl/toy_bpu_btb_arb.sv | 79 +++++++
 tb/tb_toy_bpu_btb_arb.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/toy_pack.sv
// toy_pack: shared BTB arbiter types (update request payload, arbiter state encoding)
package toy_pack;
  localparam int BTB_IDX_W = 10;
  localparam int BTB_WAY_NUM = 4;
  localparam int BTB_ENTRY_W = 64;
  typedef enum logic [1:0] {RST_WAIT, INIT, RUN, FLUSH} btb_arb_state_e;
  typedef struct packed {
    logic [BTB_IDX_W-1:0] idx;
    logic [BTB_WAY_NUM-1:0] way;
    logic [BTB_ENTRY_W-1:0] data;
  } btb_upd_req_pkg;
endpackage

// File: rtl/toy_bpu_btb_arb_if.sv
// toy_bpu_btb_arb_if: lookup/update requester, memory port and read-ack bundle of the BTB arbiter
interface toy_bpu_btb_arb_if #(
  parameter int IDX_W = 10,
  parameter int WAY_NUM = 4,
  parameter int ENTRY_W = 64
);
  logic lkp_vld;
  logic lkp_rdy;
  logic [IDX_W-1:0] lkp_idx;
  logic upd_vld;
  logic upd_rdy;
  logic [IDX_W-1:0] upd_idx;
  logic [WAY_NUM-1:0] upd_way;
  logic [ENTRY_W-1:0] upd_wdata;
  logic flush_req;
  logic busy;
  logic mem_req_vld;
  logic [WAY_NUM-1:0] mem_req_wren;
  logic [IDX_W-1:0] mem_req_addr;
  logic [ENTRY_W-1:0] mem_req_wdata;
  logic rd_ack_vld;
  logic [IDX_W-1:0] rd_ack_idx;
  modport slave (
    input lkp_vld, lkp_idx, upd_vld, upd_idx, upd_way, upd_wdata, flush_req,
    output lkp_rdy, upd_rdy, busy, mem_req_vld, mem_req_wren, mem_req_addr, mem_req_wdata,
    rd_ack_vld, rd_ack_idx
  );
  modport master (
    output lkp_vld, lkp_idx, upd_vld, upd_idx, upd_way, upd_wdata, flush_req,
    input lkp_rdy, upd_rdy, busy, mem_req_vld, mem_req_wren, mem_req_addr, mem_req_wdata,
    rd_ack_vld, rd_ack_idx
  );
endinterface

// File: rtl/toy_bpu_btb_upd_fifo.sv
// toy_bpu_btb_upd_fifo: power-of-2 FIFO with sync clear and a key match over the top KW bits of live entries
module toy_bpu_btb_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8,
  parameter int KW = 1
) (
  input logic clk,
  input logic rst_n,
  input logic clr,
  input logic push,
  input logic pop,
  input logic [W-1:0] din,
  input logic [KW-1:0] key,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic hit
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp, cnt;
  logic [DEPTH-1:0][W-1:0] mem;
  assign cnt = wp - rp;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
    end
  always_ff @(posedge clk)
    if (push && !clr) mem[wp[AW-1:0]] <= din;
  // an entry is live when its distance from the read pointer is below the occupancy
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      hit = hit | (({1'b0, AW'(i) - rp[AW-1:0]} < cnt) && mem[i][W-1 -: KW] == key);
  end
endmodule

// File: rtl/toy_bpu_btb_arb.sv
// toy_bpu_btb_arb: BTB SRAM port owner (zero sweep, update FIFO, starvation-limited arbitration); BTB_ARB_HAZARD_EN holds lookups behind queued same-index updates
module toy_bpu_btb_arb
  import toy_pack::*;
#(
  parameter int IDX_W = 10,
  parameter int WAY_NUM = 4,
  parameter int ENTRY_W = 64,
  parameter int QDEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input logic clk,
  input logic rst_n,
  toy_bpu_btb_arb_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
`ifdef BTB_ARB_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WAY_NUM-1:0] way;
    logic [ENTRY_W-1:0] data;
  } upd_t;
  btb_arb_state_e state, state_nx;
  logic [IDX_W-1:0] sweep_cnt;
  logic [SW-1:0] starve_cnt;
  logic sweep, run, clr, push, force_wr, rd_iss, full, empty, hit, hz;
  upd_t head, din;
  assign din = '{idx: bus.upd_idx, way: bus.upd_way, data: bus.upd_wdata};
  assign hz = HAZ && bus.lkp_vld && hit;
  toy_bpu_btb_upd_fifo #(.DEPTH(QDEPTH), .W($bits(upd_t)), .KW(IDX_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .push(push),
    .pop(force_wr),
    .din(din),
    .key(bus.lkp_idx),
    .dout(head),
    .full(full),
    .empty(empty),
    .hit(hit)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RST_WAIT;
    else state <= state_nx;
  always_comb begin
    sweep = state == INIT || state == FLUSH;
    run = state == RUN;
    clr = run && bus.flush_req;
    force_wr = run && !empty && (starve_cnt == SW'(STARVE_MAX) || !bus.lkp_vld || hz);
    rd_iss = run && !force_wr && bus.lkp_vld;
    state_nx = state == RST_WAIT ? INIT : sweep && &sweep_cnt ? RUN : clr ? FLUSH : state;
    bus.busy = !run;
    bus.lkp_rdy = run && !force_wr;
    bus.upd_rdy = run && !full;
    push = bus.upd_vld && bus.upd_rdy;
    bus.mem_req_vld = sweep || force_wr || rd_iss;
    bus.mem_req_wren = sweep ? '1 : force_wr ? head.way : '0;
    bus.mem_req_addr = sweep ? sweep_cnt : force_wr ? head.idx : rd_iss ? bus.lkp_idx : '0;
    bus.mem_req_wdata = force_wr ? head.data : '0;
  end
  // starvation counts only lookups that win while an update is waiting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sweep_cnt <= '0;
      starve_cnt <= '0;
      bus.rd_ack_vld <= 1'b0;
      bus.rd_ack_idx <= '0;
    end else begin
      sweep_cnt <= sweep ? sweep_cnt + 1'b1 : '0;
      starve_cnt <= (clr || force_wr || empty) ? '0 :
                    (rd_iss && starve_cnt != SW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
      bus.rd_ack_vld <= rd_iss;
      bus.rd_ack_idx <= rd_iss ? bus.lkp_idx : bus.rd_ack_idx;
    end
endmodule

// File: tb/tb_toy_bpu_btb_arb.sv
// tb_toy_bpu_btb_arb: directed scoreboard bench for toy_bpu_btb_arb at IDX_W=4 (follows BTB_ARB_HAZARD_EN)
module tb_toy_bpu_btb_arb;
  typedef struct packed {
    logic vld;
    logic [3:0] wren;
    logic [3:0] addr;
    logic [63:0] wdata;
    logic lrdy;
    logic urdy;
    logic busy;
  } obs_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];
  logic [3:0] rd_q[$];
  toy_bpu_btb_arb_if #(.IDX_W(4), .WAY_NUM(4), .ENTRY_W(64)) bus ();
  toy_bpu_btb_arb #(.IDX_W(4), .WAY_NUM(4), .ENTRY_W(64), .QDEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic obs_t mk(logic v, logic [3:0] w, logic [3:0] a, logic [63:0] d, logic l, logic u, logic b);
    return {v, w, a, d, l, u, b};
  endfunction
  function automatic obs_t e_rst();
    return mk(1'b0, 4'h0, 4'h0, 64'h0, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic obs_t e_sw(logic [3:0] a);
    return mk(1'b1, 4'hF, a, 64'h0, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic obs_t e_rd(logic [3:0] a, logic u);
    return mk(1'b1, 4'h0, a, 64'h0, 1'b1, u, 1'b0);
  endfunction
  function automatic obs_t e_wr(logic [3:0] w, logic [3:0] a, logic [63:0] d, logic u);
    return mk(1'b1, w, a, d, 1'b0, u, 1'b0);
  endfunction
  function automatic obs_t e_idle(logic l, logic u);
    return mk(1'b0, 4'h0, 4'h0, 64'h0, l, u, 1'b0);
  endfunction
  function automatic logic [63:0] dat(logic [3:0] i);
    return {32'hC0FFEE00, 24'h0, i, ~i};
  endfunction
  function automatic logic [3:0] way(logic [3:0] i);
    return 4'b0001 << i[1:0];
  endfunction
  function automatic obs_t obs();
    return {bus.mem_req_vld, bus.mem_req_wren, bus.mem_req_addr, bus.mem_req_wdata,
            bus.lkp_rdy, bus.upd_rdy, bus.busy};
  endfunction
  task automatic chk(string tag, obs_t o, obs_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic chk_ack(string tag, logic ev, logic [3:0] ei);
    logic [4:0] o, e;
    o = {bus.rd_ack_vld, ev ? bus.rd_ack_idx : 4'h0};
    e = {ev, ev ? ei : 4'h0};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s_ack observed=%h expected=%h", tag, o, e);
    end
  endtask
  // expectation queued as the cycle is driven, popped once outputs settle
  task automatic tick(string tag, obs_t e);
    obs_t x;
    exp_q.push_back(e);
    #2;
    if (rd_q.size() > 0) chk_ack(tag, 1'b1, rd_q.pop_front());
    else chk_ack(tag, 1'b0, 4'h0);
    x = exp_q.pop_front();
    chk(tag, obs(), x);
    if (x.vld && x.wren == 4'h0) rd_q.push_back(x.addr);
    @(negedge clk);
  endtask
  task automatic upd(logic [3:0] i, logic [3:0] w);
    bus.upd_vld = 1'b1;
    bus.upd_idx = i;
    bus.upd_way = w;
    bus.upd_wdata = dat(i);
  endtask
  initial begin
    bus.lkp_vld = 1'b0;
    bus.lkp_idx = 4'h0;
    bus.upd_vld = 1'b0;
    bus.upd_idx = 4'h0;
    bus.upd_way = 4'h0;
    bus.upd_wdata = 64'h0;
    bus.flush_req = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("reset_hold", obs(), e_rst());
    chk_ack("reset_hold", 1'b0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("rst_wait", e_rst());
    for (int i = 0; i < 16; i++) tick("init_sweep", e_sw(4'(i)));
    tick("run_idle", e_idle(1'b1, 1'b1));
    bus.lkp_vld = 1'b1;
    bus.lkp_idx = 4'd5;
    tick("lkp5", e_rd(4'd5, 1'b1));
    bus.lkp_vld = 1'b0;
    tick("lkp5_done", e_idle(1'b1, 1'b1));
    bus.lkp_vld = 1'b1;
    bus.lkp_idx = 4'd9;
    upd(4'd3, 4'b0010);
    tick("starve_enq", e_rd(4'd9, 1'b1));
    bus.upd_vld = 1'b0;
    for (int i = 0; i < 8; i++) tick("starve_lkp", e_rd(4'd9, 1'b1));
    tick("starve_wr", e_wr(4'b0010, 4'd3, dat(4'd3), 1'b1));
    tick("starve_resume", e_rd(4'd9, 1'b1));
    upd(4'd14, way(4'd14));
    tick("fill0", e_rd(4'd9, 1'b1));
    upd(4'd15, way(4'd15));
    tick("fill1", e_rd(4'd9, 1'b1));
    upd(4'd0, way(4'd0));
    tick("fill2", e_rd(4'd9, 1'b1));
    upd(4'd1, way(4'd1));
    tick("fill3", e_rd(4'd9, 1'b1));
    upd(4'd2, way(4'd2));
    tick("full_block", e_rd(4'd9, 1'b0));
    bus.lkp_vld = 1'b0;
    tick("drain14_full", e_wr(way(4'd14), 4'd14, dat(4'd14), 1'b0));
    tick("drain15_push", e_wr(way(4'd15), 4'd15, dat(4'd15), 1'b1));
    upd(4'd3, way(4'd3));
    tick("drain0_push", e_wr(way(4'd0), 4'd0, dat(4'd0), 1'b1));
    bus.upd_vld = 1'b0;
    tick("drain1", e_wr(way(4'd1), 4'd1, dat(4'd1), 1'b1));
    tick("drain2", e_wr(way(4'd2), 4'd2, dat(4'd2), 1'b1));
    tick("drain3", e_wr(way(4'd3), 4'd3, dat(4'd3), 1'b1));
    tick("drain_empty", e_idle(1'b1, 1'b1));
    bus.lkp_vld = 1'b1;
    upd(4'd4, way(4'd4));
    tick("fl_q4", e_rd(4'd9, 1'b1));
    upd(4'd5, way(4'd5));
    tick("fl_q5", e_rd(4'd9, 1'b1));
    upd(4'd6, way(4'd6));
    tick("fl_q6", e_rd(4'd9, 1'b1));
    bus.upd_vld = 1'b0;
    bus.flush_req = 1'b1;
    tick("fl_req", e_rd(4'd9, 1'b1));
    bus.lkp_vld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.flush_req = (i == 5);
      tick("flush_sweep", e_sw(4'(i)));
    end
    bus.flush_req = 1'b0;
    tick("flush_done", e_idle(1'b1, 1'b1));
    tick("flush_empty", e_idle(1'b1, 1'b1));
    bus.lkp_vld = 1'b1;
    bus.lkp_idx = 4'd2;
    upd(4'd7, 4'b1000);
    tick("haz_enq", e_rd(4'd2, 1'b1));
    bus.upd_vld = 1'b0;
    bus.lkp_idx = 4'd7;
`ifdef BTB_ARB_HAZARD_EN
    tick("haz_wr", e_wr(4'b1000, 4'd7, dat(4'd7), 1'b1));
    tick("haz_rd", e_rd(4'd7, 1'b1));
`else
    tick("haz_rd", e_rd(4'd7, 1'b1));
    bus.lkp_vld = 1'b0;
    tick("haz_wr", e_wr(4'b1000, 4'd7, dat(4'd7), 1'b1));
`endif
    bus.lkp_vld = 1'b0;
    tick("haz_idle", e_idle(1'b1, 1'b1));
    bus.lkp_vld = 1'b1;
    bus.lkp_idx = 4'd2;
    upd(4'd9, way(4'd9));
    tick("pre_rst", e_rd(4'd2, 1'b1));
    rst_n = 1'b0;
    bus.lkp_vld = 1'b0;
    bus.upd_vld = 1'b0;
    #2;
    chk("mid_rst", obs(), e_rst());
    chk_ack("mid_rst", 1'b0, 4'h0);
    rd_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick("rst2_wait", e_rst());
    for (int i = 0; i < 16; i++) tick("rst2_sweep", e_sw(4'(i)));
    tick("rst2_run", e_idle(1'b1, 1'b1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
